ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 "enable reporting", 0xFF "reset") from the FPGA to the mouse over the shared open-drain ps2_clk/ps2_data lines, then checks the device acknowledge. It is the transmit direction of the mouse link; the existing receive path only listens to device-to-host packets. It sits beside the mouse controller, and the top level merges its output-enables into the open-drain inout pins.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, error codes, default timing.
// Used by the host transmitter and the mouse receive path.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_WAIT_CLK,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_ERR
   } ps2_tx_state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_XFER  = 2'b10;
   localparam logic [1:0] ERR_NACK  = 2'b11;

   localparam int unsigned PS2_CLK_FREQ_HZ   = 40_000_000;
   localparam int unsigned PS2_INHIBIT_DIV   = 10_000;
   localparam int unsigned PS2_START_TO_MUL  = 15;
   localparam int unsigned PS2_START_TO_DIV  = 1_000;
   localparam int unsigned PS2_XFER_TO_DIV   = 500;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 pins plus a registered
// falling-edge pulse on the synchronized clock line.
module ps2_line_sync (
   input  logic pclk,
   input  logic rst,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic clk_m;
   logic data_m;
   logic clk_q;

   // Idle bus is high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         clk_m    <= 1'b1;
         clk_s    <= 1'b1;
         data_m   <= 1'b1;
         data_s   <= 1'b1;
         clk_q    <= 1'b1;
         clk_fall <= 1'b0;
      end else begin
         clk_m    <= ps2_clk_in;
         clk_s    <= clk_m;
         data_m   <= ps2_data_in;
         data_s   <= data_m;
         clk_q    <= clk_s;
         clk_fall <= clk_q & ~clk_s;
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one
// byte with odd parity on device clock edges, then check the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ          = PS2_CLK_FREQ_HZ,
   parameter int unsigned INHIBIT_CYCLES       = CLK_FREQ_HZ / PS2_INHIBIT_DIV,
   parameter int unsigned START_TIMEOUT_CYCLES =
      CLK_FREQ_HZ / PS2_START_TO_DIV * PS2_START_TO_MUL,
   parameter int unsigned XFER_TIMEOUT_CYCLES  = CLK_FREQ_HZ / PS2_XFER_TO_DIV
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int TW = $clog2(START_TIMEOUT_CYCLES + 1);

   localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT_CYCLES - 1);

   logic clk_s;
   logic data_s;
   logic clk_fall;

   ps2_line_sync u_sync (
      .pclk        (pclk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_s       (clk_s),
      .data_s      (data_s),
      .clk_fall    (clk_fall)
   );

   ps2_tx_state_e state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    data_q, data_n;
   logic          par_q, par_n;
   logic          clk_oe_q, clk_oe_n;
   logic          data_oe_q, data_oe_n;
   logic [1:0]    code_q, code_n;

   logic [3:0]    nxt_idx;
   logic          nxt_bit;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         bit_cnt   <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         bit_cnt   <= bit_cnt_n;
         data_q    <= data_n;
         par_q     <= par_n;
         clk_oe_q  <= clk_oe_n;
         data_oe_q <= data_oe_n;
         code_q    <= code_n;
      end
   end

   // bit_cnt names the bit currently on the line; index 8 is parity.
   assign nxt_idx = bit_cnt + 4'd1;
   assign nxt_bit = (nxt_idx == 4'd8) ? par_q : data_q[nxt_idx[2:0]];

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      bit_cnt_n = bit_cnt;
      data_n    = data_q;
      par_n     = par_q;
      clk_oe_n  = clk_oe_q;
      data_oe_n = data_oe_q;
      code_n    = code_q;
      tx_done   = 1'b0;
      tx_err    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (tx_valid) begin
               data_n   = tx_data;
               par_n    = odd_parity(tx_data);
               code_n   = ERR_NONE;
               timer_n  = '0;
               clk_oe_n = 1'b1;
               state_n  = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (timer == INH_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               timer_n   = '0;
               state_n   = ST_WAIT_CLK;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         ST_WAIT_CLK: begin
            if (timer == START_LAST) begin
               data_oe_n = 1'b0;
               code_n    = ERR_START;
               state_n   = ST_ERR;
            end else if (clk_fall) begin
               // First device clock: the start bit has been taken, put D0 out.
               data_oe_n = ~data_q[0];
               bit_cnt_n = '0;
               timer_n   = '0;
               state_n   = ST_SHIFT;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         ST_SHIFT: begin
            if (timer == XFER_LAST) begin
               data_oe_n = 1'b0;
               code_n    = ERR_XFER;
               state_n   = ST_ERR;
            end else begin
               timer_n = timer + 1'b1;
               if (clk_fall) begin
                  if (bit_cnt == 4'd8) begin
                     data_oe_n = 1'b0;
                     state_n   = ST_ACK;
                  end else begin
                     bit_cnt_n = nxt_idx;
                     data_oe_n = ~nxt_bit;
                  end
               end
            end
         end

         ST_ACK: begin
            if (timer == XFER_LAST) begin
               code_n  = ERR_XFER;
               state_n = ST_ERR;
            end else begin
               timer_n = timer + 1'b1;
               if (clk_fall) begin
                  if (!data_s) begin
                     state_n = ST_WAIT_IDLE;
                  end else begin
                     code_n  = ERR_NACK;
                     state_n = ST_ERR;
                  end
               end
            end
         end

         ST_WAIT_IDLE: begin
            if (clk_s && data_s) begin
               tx_done = 1'b1;
               state_n = ST_IDLE;
            end
         end

         ST_ERR: begin
            tx_err    = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = ST_IDLE;
         end

         default: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = ST_IDLE;
         end
      endcase
   end

   assign tx_ready    = (state == ST_IDLE);
   assign err_code    = code_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a scaled-clock PS/2 device model.
// pclk is 200 kHz nominal so the derived timing stays short.
module tb_ps2_host_tx;

   // CLK_FREQ_HZ = 200_000: inhibit 20, start timeout 3000, xfer 400.
   localparam int INH   = 20;
   localparam int START = 3000;
   localparam int XFER  = 400;
   localparam int HALF  = 10;

   typedef struct {
      logic       err;
      logic [1:0] code;
   } ev_t;

   logic       pclk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic [1:0] err_code;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;

   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;

   int n_pass = 0;
   int n_chk = 0;
   int cyc = 0;
   int first_fall = 0;

   logic [9:0] exp_q[$];
   logic [9:0] rx_q[$];
   ev_t        ev_q[$];

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.CLK_FREQ_HZ(200_000)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .err_code    (err_code),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 pclk = ~pclk;

   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic ev_t mk_ev(input logic err, input logic [1:0] code);
      ev_t e;
      e.err  = err;
      e.code = code;
      return e;
   endfunction

   // Device model: clocks nclk bits, samples on rising edges,
   // ACKs (data low) across the 11th clock when ack is set.
   task automatic dev_frame(input int nclk, input bit ack);
      int n = 0;
      logic [9:0] f = '0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 200) begin
         @(negedge pclk);
         n++;
      end
      check("bfm_rts", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      repeat (HALF) @(negedge pclk);
      for (int i = 0; i < nclk; i++) begin
         if (i == 0) first_fall = cyc;
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge pclk);
         dev_clk_low = 1'b0;
         if (i < 10) f[i] = ps2_data_in;
         if (i == 9) begin
            rx_q.push_back(f);
            if (ack) dev_data_low = 1'b1;
         end
         if (i == 10) dev_data_low = 1'b0;
         repeat (HALF) @(negedge pclk);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 2000) begin
         @(posedge pclk); #1;
         n++;
      end
      check("ready_wait", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge pclk); #1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check("accept", {ps2_clk_oe, tx_ready}, 2'b10);
      n = 1;
      while (ps2_clk_oe && n < INH + 10) begin
         @(posedge pclk); #1;
         if (ps2_clk_oe) n++;
      end
      check("inhibit_len", n, INH);
      check("start_bit", ps2_data_oe, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (ev_q.size() != 0 && n < 3000) begin
         @(posedge pclk); #1;
         n++;
      end
      check("drain", ev_q.size(), 0);
   endtask

   task automatic wait_err(output int t);
      int n = 0;
      while (!tx_err && n < START + 100) begin
         @(posedge pclk); #1;
         n++;
      end
      t = cyc;
   endtask

   // Monitor: compares sampled frames and done/err pulses with the queues.
   logic [9:0] mon_f;
   ev_t        mon_e;
   initial forever begin
      @(posedge pclk); #1;
      if (rx_q.size() != 0) begin
         mon_f = rx_q.pop_front();
         check("frame_queue", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("frame_bits", mon_f, exp_q.pop_front());
      end
      if (tx_done || tx_err) begin
         check("ev_queue", ev_q.size() != 0, 1);
         if (ev_q.size() != 0) begin
            mon_e = ev_q.pop_front();
            check("pulse", {tx_err, tx_done, err_code},
                  {mon_e.err, ~mon_e.err, mon_e.code});
         end
         @(posedge pclk); #1;
         check("pulse_width", {tx_done, tx_err, tx_ready}, 3'b001);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int t1;
      repeat (3) @(posedge pclk); #1;
      check("reset_vals",
            {tx_ready, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe},
            7'b100_0000);
      @(negedge pclk);
      rst = 1'b1;
      @(posedge pclk); #1;

      // F4: 0,0,1,0,1,1,1,1 then parity 0, stop 1.
      exp_q.push_back(10'b1_0_1111_0100);
      ev_q.push_back(mk_ev(1'b0, 2'b00));
      send(8'hF4);
      dev_frame(11, 1'b1);
      drain();

      // FF and 00 both carry parity 1.
      exp_q.push_back(10'b1_1_1111_1111);
      ev_q.push_back(mk_ev(1'b0, 2'b00));
      send(8'hFF);
      dev_frame(11, 1'b1);
      drain();

      exp_q.push_back(10'b1_1_0000_0000);
      ev_q.push_back(mk_ev(1'b0, 2'b00));
      send(8'h00);
      dev_frame(11, 1'b1);
      drain();

      // Device never clocks.
      ev_q.push_back(mk_ev(1'b1, 2'b01));
      send(8'h55);
      t0 = cyc;
      wait_err(t1);
      check("start_to_len", t1 - t0, START);
      check("start_to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      drain();

      // Device leaves data high on the 11th clock.
      exp_q.push_back(10'b1_0_1111_0100);
      ev_q.push_back(mk_ev(1'b1, 2'b11));
      send(8'hF4);
      dev_frame(11, 1'b0);
      drain();
      repeat (5) @(posedge pclk); #1;
      check("code_hold", err_code, 2'b11);

      // Five clocks then silence; expiry counted from SHIFT entry,
      // which trails the first pin fall by the 4-cycle edge latency.
      ev_q.push_back(mk_ev(1'b1, 2'b10));
      send(8'hA5);
      dev_frame(5, 1'b1);
      wait_err(t1);
      check("xfer_to_len", t1 - first_fall, XFER + 4);
      check("xfer_to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      drain();

      // Reset while shifting D3 (=0, so data is driven low).
      send(8'hF4);
      dev_frame(4, 1'b1);
      check("pre_rst", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b010);
      rst = 1'b0;
      #1;
      check("rst_async",
            {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err},
            5'b00100);
      repeat (3) @(negedge pclk);
      rst = 1'b1;
      @(posedge pclk); #1;

      exp_q.push_back(10'b1_0_1111_0100);
      ev_q.push_back(mk_ev(1'b0, 2'b00));
      send(8'hF4);
      dev_frame(11, 1'b1);
      drain();

      repeat (5) @(posedge pclk); #1;
      check("frames_left", exp_q.size() + rx_q.size(), 0);
      check("idle_end", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
